// File: rtl/pulse_level_sequencer.sv
// pulse_level_sequencer
// Turns single-cycle request pulses into held-high service levels.
// Requests that arrive while a unit is busy queue in a saturating counter.
// Each level is released by the unit's done pulse, or by a timeout.
// A fixed idle gap then follows before the next level may start.
// The flags ovf (dropped request) and err (spurious done or timeout)
// are sticky until clr.
module pulse_level_sequencer #(
    parameter int CNT_W = 4,
    parameter int GAP   = 2,
    parameter int TMO   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             done,
    input  logic             clr,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             ovf,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Timer sized to hold TMO-1, the last RUN cycle before a forced release
    localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(TMO - 1);
    localparam logic [TW-1:0]    TMR_ONE  = TW'(1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP - 1);
    localparam logic [3:0]       GAP_ONE  = 4'd1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic [TW-1:0]    tmo_cnt;
    logic [3:0]       gap_cnt;
    logic             tmo_hit;
    logic             start;
    logic             out_nxt, busy_nxt;
    logic [CNT_W-1:0] pending_nxt;
    logic             drop, err_evt;
    logic             ovf_nxt, err_nxt;

    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign start   = (state == ST_IDLE) && ((pending != '0) || in);

    // State register; out and busy are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            out   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state logic: done takes priority over a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (done || tmo_hit) state_nxt = ST_GAP;
            ST_GAP:  if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode of the next state, captured by the state register
    always_comb begin
        out_nxt  = (state_nxt == ST_RUN);
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // Request counter and sticky-flag next values
    always_comb begin
        pending_nxt = pending;
        drop        = 1'b0;
        if (start) begin
            // A new pulse in the starting cycle replaces the slot being freed
            if ((pending != '0) && !in) pending_nxt = pending - CNT_ONE;
        end else if (in) begin
            if (pending == CNT_MAX) drop = 1'b1;
            else                    pending_nxt = pending + CNT_ONE;
        end
        err_evt = (done && (state != ST_RUN)) ||
                  ((state == ST_RUN) && tmo_hit && !done);
        // A new event outranks a coincident clear
        ovf_nxt = drop    | (ovf & ~clr);
        err_nxt = err_evt | (err & ~clr);
    end

    // Counter, flags and the RUN/GAP cycle timers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            ovf     <= ovf_nxt;
            err     <= err_nxt;
            tmo_cnt <= (state == ST_RUN) ? tmo_cnt + TMR_ONE : '0;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_ONE : 4'd0;
        end
    end

endmodule

// File: tb/tb_pulse_level_sequencer.sv
// Scoreboard bench for pulse_level_sequencer (CNT_W=2, GAP=2, TMO=8).
// The stimulus side advances an integer reference model each clock and
// queues the expected outputs.
// A negedge monitor pops the queue and compares the entries against the DUT.
module tb_pulse_level_sequencer;

    localparam int CNT_W = 2;
    localparam int GAP   = 2;
    localparam int TMO   = 8;
    localparam int MAXP  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, in, done, clr;
    logic             out, busy, ovf, err;
    logic [CNT_W-1:0] pending;

    pulse_level_sequencer #(.CNT_W(CNT_W), .GAP(GAP), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .in(in), .done(done), .clr(clr),
        .out(out), .busy(busy), .pending(pending), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             out;
        logic             busy;
        logic [CNT_W-1:0] pending;
        logic             ovf;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: running flag, length of the current level,
    // remaining gap cycles, and the queued request count
    bit m_run;
    int m_len, m_gap, m_pend;
    bit m_ovf, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_len = 0; m_gap = 0; m_pend = 0; m_ovf = 0; m_err = 0;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.out     = m_run;
        e.busy    = m_run || (m_gap > 0);
        e.pending = CNT_W'(m_pend);
        e.ovf     = m_ovf;
        e.err     = m_err;
        return e;
    endfunction

    function automatic void model_step(input bit i, input bit d, input bit c);
        bit ev_err, ev_ovf, started;
        ev_err  = (d && !m_run) || (m_run && !d && m_len == TMO);
        ev_ovf  = 0;
        started = 0;
        if (m_run) begin
            if (d || m_len == TMO) begin
                m_run = 0;
                m_gap = GAP;
            end else begin
                m_len++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (m_pend > 0 || i) begin
            started = 1;
            m_run   = 1;
            m_len   = 1;
            if (m_pend > 0) m_pend = m_pend + int'(i) - 1;
        end
        if (!started && i) begin
            if (m_pend == MAXP) ev_ovf = 1;
            else                m_pend++;
        end
        m_ovf = ev_ovf || (m_ovf && !c);
        m_err = ev_err || (m_err && !c);
    endfunction

    task automatic step(input bit i, input bit d, input bit c);
        in = i; done = d; clr = c;
        @(posedge clk);
        model_step(i, d, c);
        sb.push_back(model_exp());
        #1;
    endtask

    // done fires on the done_at-th high cycle of a level (0 = never)
    task automatic run_cycles(input int n, input int p_in, input int done_at);
        for (int k = 0; k < n; k++)
            step($urandom_range(99) < p_in, m_run && (m_len == done_at), 1'b0);
    endtask

    // Monitor: compare each registered response half a cycle after the edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out", out, e.out);
            chk("busy", busy, e.busy);
            chk("pending", pending, e.pending);
            chk("ovf", ovf, e.ovf);
            chk("err", err, e.err);
        end
    end

    initial begin
        reset = 1'b1; in = 1'b0; done = 1'b0; clr = 1'b0;
        model_reset();
        #12;
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        @(negedge clk) reset = 1'b0;

        // Single request, released by done on its fifth high cycle
        repeat (4) step(0, 0, 0);
        step(1, 0, 0);
        run_cycles(10, 0, 5);

        // Burst of three pulses while idle
        repeat (3) step(1, 0, 0);
        run_cycles(30, 0, 4);

        // Saturation: five pulses while a level is held
        step(1, 0, 0);
        repeat (5) step(1, 0, 0);
        step(0, 0, 1);
        // Queue drains with every level timing out
        run_cycles(80, 0, 0);

        // Spurious done while idle, then done together with clr
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        // Asynchronous reset mid-level with two queued requests
        repeat (3) step(1, 0, 0);
        chk("pre_rst_pending", pending, m_pend);
        #2;
        reset = 1'b1; in = 1'b0; done = 1'b0; clr = 1'b0;
        #1;
        chk("arst_out", out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pending", pending, 0);
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        run_cycles(10, 0, 5);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            bit ri, rd, rc;
            ri = ($urandom_range(99) < 30);
            rd = m_run ? ($urandom_range(99) < 25) : ($urandom_range(99) < 2);
            rc = ($urandom_range(99) < 5);
            step(ri, rd, rc);
        end
        step(0, 0, 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_level_sequencer.md
Name: pulse_level_sequencer

Overview:
- Pulse-to-level converter and request sequencer.
- Takes single-cycle request pulses (the output of the team's level-to-pulse edge detectors) and queues them in a saturating counter.
- Drives a held-high `out` level to one GF(3^M) arithmetic unit per request; each level is released by that unit's one-cycle `done` pulse, then a fixed idle gap follows.
- Sits between the top-level controller and long-latency units (multiplier, inverter, pairing core).

Parameters:
- CNT_W, 4: width of the pending-request counter; saturates at 2^CNT_W-1.
- GAP, 2: idle cycles forced after each `out` deassertion; legal range 1..15.
- TMO, 1024: maximum cycles `out` may stay high without `done`; legal range 2..65535.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; all state cleared immediately.
- in  input  1  request pulse; each high cycle is one request.
- done  input  1  completion pulse from the downstream unit.
- clr  input  1  synchronous clear of the sticky flags `ovf` and `err`.
- out  output  1  level; high while a request is being serviced.
- busy  output  1  high in RUN or GAP.
- pending  output  CNT_W  queued requests not yet started.
- ovf  output  1  sticky; a request was dropped because the counter was saturated.
- err  output  1  sticky; a spurious `done` or a timeout occurred.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE. out=0, busy=0, pending=0, ovf=0, err=0, internal timers=0. Asserting reset mid-RUN drops `out` in the same instant and discards queued requests.
- All outputs are registered. There are three states: IDLE, RUN, GAP.
- IDLE
  - If pending!=0 or in=1: go to RUN next cycle and set out=1 next cycle.
  - Latency from an `in` pulse at cycle t (IDLE, pending=0) to out=1 is one cycle (out high at t+1).
  - Counter update on this transition: pending_next = pending + in - 1 when pending!=0; pending unchanged when pending=0 and in=1.
- RUN
  - out=1 and the timeout counter increments each cycle.
  - done=1: go to GAP next cycle (out=0 at t+1).
  - Timeout counter reaches TMO-1 without done: go to GAP and set err=1.
  - done and timeout in the same cycle count as done, with no err.
- GAP
  - out=0, busy=1. Stay exactly GAP cycles, then go to IDLE.
  - A queued request then starts one cycle later, so the minimum spacing between `out` levels is GAP+1 low cycles.
- Counter, all states except the IDLE->RUN transition: in=1 increments pending.
  - If pending==2^CNT_W-1, the request is dropped and ovf is set; pending holds.
  - On the IDLE->RUN transition, in=1 at saturation is not dropped, because one slot frees in the same cycle.
  - pending never wraps in either direction.
- done outside RUN: ignored for sequencing and sets err.
- clr=1 clears ovf and err next cycle. If clr coincides with a new error event, the event wins and the flag reads 1.
- busy = (state!=IDLE), registered together with the state.

Test Plan:
- Single request: reset, then one `in` pulse at cycle 5 and done at cycle 10. Required: out high cycles 6..10, low from 11; busy high 6..12; IDLE at 13; pending stays 0.
- Burst: three consecutive `in` pulses while IDLE, done 4 cycles after each out rise (GAP=2). Required: pending goes 0->1->2, then decrements at each IDLE->RUN; three separate out levels, each separated by exactly 3 low cycles.
- Saturation with CNT_W=2: hold out in RUN and send 5 pulses. Required: pending stops at 3, ovf=1 after the 4th accepted pulse attempt, no wrap; clr pulse then returns ovf=0 while pending stays 3.
- Timeout with TMO=8: one request, done never asserted. Required: out high for exactly 8 cycles, then err=1 and GAP, then IDLE.
- Spurious done: done pulse while IDLE. Required: err=1 next cycle, out stays 0. Then done and clr in the same cycle. Required: err reads 1.
- Asynchronous reset mid-RUN: assert reset between clock edges while out=1 and pending=2. Required: out, busy and pending are 0 before the next edge; after release, new `in` pulses behave as in the single-request case.
